pipe_register: RTL

PIPE_REGISTER -- requirements
Module: pipe_register

---
 rtl/pipe_register_pkg.sv | 12 +
 rtl/pipe_register_stage.sv | 47 ++++
 rtl/pipe_register.sv | 106 ++++++++++
 3 files changed

// File: rtl/pipe_register_pkg.sv
// Shared constants and helpers for the pipe_register slice.
package pipe_register_pkg;

  localparam int DEF_WORD_LENGTH = 16;
  localparam int DEF_DEPTH       = 2;

  // Bits needed to count 0..depth valid stages.
  function automatic int occ_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_register_stage.sv
// pipe_stage: one data word plus its valid bit, with load/drop/clear control.
module pipe_stage
  import pipe_register_pkg::*;
#(
  parameter int WORD_LENGTH = DEF_WORD_LENGTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_i,
  input  logic                   drop_i,
  input  logic                   clear_i,
  input  logic [WORD_LENGTH-1:0] data_i,
  output logic                   valid_o,
  output logic [WORD_LENGTH-1:0] data_o
);

  logic                   valid_q, valid_d;
  logic [WORD_LENGTH-1:0] data_q, data_d;

  // clear wins over a simultaneous load; data is never cleared except by reset
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (drop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_register.sv
// Elastic DEPTH-stage pipeline register with valid/ready handshake and flush.
// Optional occupancy counter compiled in with PIPE_REGISTER_OCC_EN.
module pipe_register
  import pipe_register_pkg::*;
#(
  parameter int WORD_LENGTH = DEF_WORD_LENGTH,
  parameter int DEPTH       = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [WORD_LENGTH-1:0] in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [WORD_LENGTH-1:0] out_data,
  input  logic                   out_ready
`ifdef PIPE_REGISTER_OCC_EN
  ,
  output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

  logic [DEPTH-1:0]       stage_valid;
  logic [DEPTH-1:0]       advance;
  logic [DEPTH-1:0]       load;
  logic [WORD_LENGTH-1:0] stage_data [DEPTH];

  // Advance resolves from the output stage backwards so a full pipe still moves.
  always_comb begin
    advance = '0;
    advance[DEPTH-1] = stage_valid[DEPTH-1] & out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      advance[i] = stage_valid[i] & (~stage_valid[i+1] | advance[i+1]);
    end
  end

  assign in_ready = (~stage_valid[0] | advance[0]) & ~flush;

  always_comb begin
    load    = '0;
    load[0] = in_valid & in_ready;
    for (int i = 1; i < DEPTH; i++) begin
      load[i] = advance[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_first
      pipe_stage #(.WORD_LENGTH(WORD_LENGTH)) u_stage (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load[g]),
        .drop_i  (advance[g]),
        .clear_i (flush),
        .data_i  (in_data),
        .valid_o (stage_valid[g]),
        .data_o  (stage_data[g])
      );
    end else begin : g_rest
      pipe_stage #(.WORD_LENGTH(WORD_LENGTH)) u_stage (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load[g]),
        .drop_i  (advance[g]),
        .clear_i (flush),
        .data_i  (stage_data[g-1]),
        .valid_o (stage_valid[g]),
        .data_o  (stage_data[g])
      );
    end
  end

  assign out_valid = stage_valid[DEPTH-1];
  assign out_data  = stage_data[DEPTH-1];

`ifdef PIPE_REGISTER_OCC_EN
  localparam int OW = occ_width(DEPTH);

  logic [OW-1:0] occ_q, occ_d;
  logic          in_xfer, out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = advance[DEPTH-1] & ~flush;

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q + OW'(in_xfer) - OW'(out_xfer);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;
`endif

endmodule
